// File: rtl/stopwatch_core_pkg.sv
// Shared constants and helpers for the BCD stopwatch core: state codes,
// digit limits, bus width derivation and preset saturation.
package stopwatch_core_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam int MAX_TW = 20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int tw_of(input int min_digits);
    return 12 + DIGIT_W * min_digits;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Nibble 2 is tens-of-seconds (limit 5); every other nibble is a decimal digit.
  function automatic logic [MAX_TW-1:0] sat_bcd(input logic [MAX_TW-1:0] p);
    logic [MAX_TW-1:0] r;
    logic [3:0] n;
    logic [3:0] lim;
    r = '0;
    for (int i = 0; i < MAX_TW / DIGIT_W; i++) begin
      n   = p[4*i +: 4];
      lim = (i == 2) ? TENS_MAX : DIGIT_MAX;
      r[4*i +: 4] = (n > lim) ? lim : n;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control/data bundle between the tick/button front end and the stopwatch core.
interface stopwatch_core_if
  import stopwatch_core_pkg::*;
#(
  parameter int MIN_DIGITS = 1
);
  localparam int TW = tw_of(MIN_DIGITS);

  logic          TICK;
  logic          START_STOP;
  logic          CLEAR;
  logic          LOAD;
  logic [TW-1:0] PRESET;
  logic          MODE;
  logic          LAP;
  logic [TW-1:0] TIME;
  logic [TW-1:0] DISP;
  logic          RUNNING;
  logic          DONE;
  logic          LAP_HELD;

  modport master (
    output TICK, START_STOP, CLEAR, LOAD, PRESET, MODE, LAP,
    input  TIME, DISP, RUNNING, DONE, LAP_HELD
  );

  modport slave (
    input  TICK, START_STOP, CLEAR, LOAD, PRESET, MODE, LAP,
    output TIME, DISP, RUNNING, DONE, LAP_HELD
  );
endinterface

// File: rtl/stopwatch_core_bcd_updown_digit.sv
// One BCD digit of the time chain: wraps at MOD-1/0 and flags carry/borrow.
module bcd_updown_digit #(
  parameter logic [3:0] MOD = 4'd10
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       UP,
  input  logic       LOAD,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic [3:0] Q_NXT,
  output logic       CARRY_OUT
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (LOAD) begin
      q_d = D;
    end else if (CE) begin
      if (UP) q_d = (q_q == MOD - 4'd1) ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? MOD - 4'd1 : q_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) q_q <= 4'd0;
    else          q_q <= q_d;
  end

  assign Q         = q_q;
  assign Q_NXT     = q_d;
  assign CARRY_OUT = UP ? (q_q == MOD - 4'd1) : (q_q == 4'd0);

endmodule

// File: rtl/stopwatch_core.sv
// Cascaded BCD stopwatch: run/pause, up/down, preset load, terminal stop, lap hold.
//   state | meaning
//   IDLE  | cleared or freshly loaded, waiting for START_STOP
//   RUN   | counting on TICK
//   PAUSE | time frozen, START_STOP resumes
//   DONE  | terminal value reached, only CLEAR/LOAD leave
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int MIN_DIGITS  = 1,
  parameter int MAX_MINUTES = 5
) (
  input logic CLK,
  input logic RESET_N,
  stopwatch_core_if.slave bus
);

  localparam int TW = tw_of(MIN_DIGITS);
  localparam int ND = 3 + MIN_DIGITS;
  localparam logic [7:0] MAX_BCD   = to_bcd(MAX_MINUTES);
  localparam logic [7:0] MAXM1_BCD = to_bcd(MAX_MINUTES - 1);
  localparam logic [TW-1:0] TERM_MAX    = {MAX_BCD[4*MIN_DIGITS-1:0], 12'h000};
  localparam logic [TW-1:0] TERM_UP_PRE = {MAXM1_BCD[4*MIN_DIGITS-1:0], 12'h599};
  localparam logic [TW-1:0] TERM_DN_PRE = TW'(1);

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic              lap_held_q, lap_held_d;
  logic              running_q, done_q;
  logic [TW-1:0]     disp_q, disp_d;
  logic [TW-1:0]     time_q, time_nxt, load_val;
  logic [MAX_TW-1:0] preset_sat;
  logic [ND-1:0]     ce, carry;
  logic              count_en, load_en, up_dir, tick_terminal, start_terminal;

  assign up_dir     = ~mode_q;
  assign count_en   = (state_q == ST_RUN) & bus.TICK & ~bus.CLEAR;
  assign load_en    = bus.CLEAR | (bus.LOAD & (state_q != ST_RUN));
  assign preset_sat = sat_bcd(MAX_TW'(bus.PRESET));
  assign load_val   = bus.CLEAR ? '0 : preset_sat[TW-1:0];
  // Terminal is detected one step early so the final value and DONE land together.
  assign tick_terminal  = count_en & (mode_q ? (time_q == TERM_DN_PRE) : (time_q == TERM_UP_PRE));
  assign start_terminal = bus.MODE ? (time_q == '0) : (time_q >= TERM_MAX);

  always_comb begin
    ce[0] = count_en;
    for (int i = 1; i < ND; i++) ce[i] = ce[i-1] & carry[i-1];
  end

  for (genvar g = 0; g < ND; g++) begin : g_dig
    localparam logic [3:0] M = (g == 2) ? 4'd6 : 4'd10;
    bcd_updown_digit #(.MOD(M)) u_dig (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .CE       (ce[g]),
      .UP       (up_dir),
      .LOAD     (load_en),
      .D        (load_val[4*g +: 4]),
      .Q        (time_q[4*g +: 4]),
      .Q_NXT    (time_nxt[4*g +: 4]),
      .CARRY_OUT(carry[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    lap_held_d = lap_held_q;
    if (load_en) begin
      state_d    = ST_IDLE;
      lap_held_d = 1'b0;
    end else if (tick_terminal) begin
      state_d    = ST_DONE;
      lap_held_d = 1'b0;
    end else if (bus.START_STOP) begin
      case (state_q)
        ST_IDLE: begin
          mode_d     = bus.MODE;
          state_d    = start_terminal ? ST_DONE : ST_RUN;
          lap_held_d = 1'b0;
        end
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (bus.LAP) begin
      lap_held_d = (state_q == ST_RUN) ? ~lap_held_q : 1'b0;
    end
    disp_d = (lap_held_d & lap_held_q) ? disp_q : time_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      lap_held_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      lap_held_q <= lap_held_d;
      running_q  <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
      disp_q     <= disp_d;
    end
  end

  assign bus.TIME     = time_q;
  assign bus.DISP     = disp_q;
  assign bus.RUNNING  = running_q;
  assign bus.DONE     = done_q;
  assign bus.LAP_HELD = lap_held_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: default 1-digit/5-minute instance plus a 2-digit/12-minute one.
module tb_stopwatch_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_core_if #(.MIN_DIGITS(1)) sw1 ();
  stopwatch_core_if #(.MIN_DIGITS(2)) sw2 ();

  stopwatch_core #(.MIN_DIGITS(1), .MAX_MINUTES(5)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .bus(sw1.slave)
  );
  stopwatch_core #(.MIN_DIGITS(2), .MAX_MINUTES(12)) dut2 (
    .CLK(clk), .RESET_N(rst2_n), .bus(sw2.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      sw1.TICK = 1'b1;
      step();
      sw1.TICK = 1'b0;
    end
  endtask

  task automatic pulse_ss();
    sw1.START_STOP = 1'b1; step(); sw1.START_STOP = 1'b0;
  endtask

  task automatic pulse_clear();
    sw1.CLEAR = 1'b1; step(); sw1.CLEAR = 1'b0;
  endtask

  task automatic pulse_lap();
    sw1.LAP = 1'b1; step(); sw1.LAP = 1'b0;
  endtask

  task automatic load1(input logic [15:0] p);
    sw1.PRESET = p; sw1.LOAD = 1'b1; step(); sw1.LOAD = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (sw1.TIME !== 16'h0 || sw1.DISP !== 16'h0 || sw1.RUNNING !== 1'b0 ||
        sw1.DONE !== 1'b0 || sw1.LAP_HELD !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: time=%h disp=%h run=%b done=%b lap=%b, want all 0",
               sw1.TIME, sw1.DISP, sw1.RUNNING, sw1.DONE, sw1.LAP_HELD);
    end
    step();
    rst_n = 1'b1;
    rst2_n = 1'b1;
    step();
  endtask

  task automatic test_up_terminal();
    sw1.MODE = 1'b0;
    pulse_ss();
    ticks(2999);
    n_checks++;
    if (sw1.TIME !== 16'h4599 || sw1.RUNNING !== 1'b1) begin
      n_fail++;
      $display("FAIL up_before_term: time=%h run=%b, want 4599 run=1", sw1.TIME, sw1.RUNNING);
    end
    ticks(1);
    n_checks++;
    if (sw1.TIME !== 16'h5000 || sw1.DONE !== 1'b1 || sw1.RUNNING !== 1'b0) begin
      n_fail++;
      $display("FAIL up_term: time=%h done=%b run=%b, want 5000 1 0", sw1.TIME, sw1.DONE, sw1.RUNNING);
    end
    ticks(10);
    n_checks++;
    if (sw1.TIME !== 16'h5000 || sw1.DISP !== 16'h5000) begin
      n_fail++;
      $display("FAIL up_hold_after_done: time=%h disp=%h, want 5000", sw1.TIME, sw1.DISP);
    end
  endtask

  task automatic test_carry();
    pulse_clear();
    n_checks++;
    if (sw1.TIME !== 16'h0 || sw1.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL clear: time=%h done=%b, want 0 0", sw1.TIME, sw1.DONE);
    end
    pulse_ss();
    ticks(599);
    n_checks++;
    if (sw1.TIME !== 16'h0599) begin
      n_fail++;
      $display("FAIL carry_599: time=%h, want 0599", sw1.TIME);
    end
    ticks(1);
    n_checks++;
    if (sw1.TIME !== 16'h1000 || sw1.DISP !== 16'h1000) begin
      n_fail++;
      $display("FAIL carry_minute: time=%h disp=%h, want 1000", sw1.TIME, sw1.DISP);
    end
    pulse_clear();
  endtask

  task automatic test_load_saturate();
    load1(16'hAF9C);
    n_checks++;
    if (sw1.TIME !== 16'h9599) begin
      n_fail++;
      $display("FAIL load_sat: time=%h, want 9599", sw1.TIME);
    end
  endtask

  task automatic test_down();
    load1(16'h0012);
    sw1.MODE = 1'b1;
    pulse_ss();
    ticks(11);
    n_checks++;
    if (sw1.TIME !== 16'h0001 || sw1.DONE !== 1'b0 || sw1.RUNNING !== 1'b1) begin
      n_fail++;
      $display("FAIL down_pre: time=%h done=%b run=%b, want 0001 0 1", sw1.TIME, sw1.DONE, sw1.RUNNING);
    end
    ticks(1);
    n_checks++;
    if (sw1.TIME !== 16'h0000 || sw1.DONE !== 1'b1 || sw1.RUNNING !== 1'b0) begin
      n_fail++;
      $display("FAIL down_term: time=%h done=%b run=%b, want 0000 1 0", sw1.TIME, sw1.DONE, sw1.RUNNING);
    end
    load1(16'h0000);
    pulse_ss();
    n_checks++;
    if (sw1.DONE !== 1'b1 || sw1.RUNNING !== 1'b0 || sw1.TIME !== 16'h0) begin
      n_fail++;
      $display("FAIL down_start_zero: done=%b run=%b time=%h, want 1 0 0000", sw1.DONE, sw1.RUNNING, sw1.TIME);
    end
    sw1.MODE = 1'b0;
  endtask

  task automatic test_lap();
    pulse_clear();
    load1(16'h0100);
    pulse_ss();
    pulse_lap();
    n_checks++;
    if (sw1.LAP_HELD !== 1'b1 || sw1.DISP !== 16'h0100) begin
      n_fail++;
      $display("FAIL lap_set: held=%b disp=%h, want 1 0100", sw1.LAP_HELD, sw1.DISP);
    end
    ticks(50);
    n_checks++;
    if (sw1.TIME !== 16'h0150 || sw1.DISP !== 16'h0100) begin
      n_fail++;
      $display("FAIL lap_hold: time=%h disp=%h, want 0150 0100", sw1.TIME, sw1.DISP);
    end
    pulse_lap();
    n_checks++;
    if (sw1.LAP_HELD !== 1'b0 || sw1.DISP !== 16'h0150) begin
      n_fail++;
      $display("FAIL lap_release: held=%b disp=%h, want 0 0150", sw1.LAP_HELD, sw1.DISP);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    load1(16'h0020);
    pulse_ss();
    sw1.TICK = 1'b1; sw1.START_STOP = 1'b1; step();
    n_checks++;
    if (sw1.TIME !== 16'h0021 || sw1.RUNNING !== 1'b0 || sw1.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_ss_run: time=%h run=%b done=%b, want 0021 0 0", sw1.TIME, sw1.RUNNING, sw1.DONE);
    end
    step();
    n_checks++;
    if (sw1.TIME !== 16'h0021 || sw1.RUNNING !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_ss_pause: time=%h run=%b, want 0021 1", sw1.TIME, sw1.RUNNING);
    end
    sw1.START_STOP = 1'b0; step(); sw1.TICK = 1'b0;
    n_checks++;
    if (sw1.TIME !== 16'h0022) begin
      n_fail++;
      $display("FAIL resume_tick: time=%h, want 0022", sw1.TIME);
    end
    sw1.PRESET = 16'h0345; sw1.CLEAR = 1'b1; sw1.LOAD = 1'b1; step();
    sw1.CLEAR = 1'b0; sw1.LOAD = 1'b0;
    n_checks++;
    if (sw1.TIME !== 16'h0 || sw1.RUNNING !== 1'b0 || sw1.DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_over_load: time=%h run=%b done=%b, want 0 0 0", sw1.TIME, sw1.RUNNING, sw1.DONE);
    end
  endtask

  task automatic test_wide();
    sw2.PRESET = 20'h99999; sw2.LOAD = 1'b1; step(); sw2.LOAD = 1'b0;
    n_checks++;
    if (sw2.TIME !== 20'h99599) begin
      n_fail++;
      $display("FAIL wide_load_sat: time=%h, want 99599", sw2.TIME);
    end
    sw2.PRESET = 20'h11599; sw2.LOAD = 1'b1; step(); sw2.LOAD = 1'b0;
    sw2.MODE = 1'b0; sw2.START_STOP = 1'b1; step(); sw2.START_STOP = 1'b0;
    sw2.TICK = 1'b1; step(); sw2.TICK = 1'b0;
    n_checks++;
    if (sw2.TIME !== 20'h12000 || sw2.DONE !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_term: time=%h done=%b, want 12000 1", sw2.TIME, sw2.DONE);
    end
    sw2.CLEAR = 1'b1; step(); sw2.CLEAR = 1'b0;
    sw2.START_STOP = 1'b1; step(); sw2.START_STOP = 1'b0;
    sw2.TICK = 1'b1; repeat (5) step(); sw2.TICK = 1'b0;
    n_checks++;
    if (sw2.TIME !== 20'h00005 || sw2.RUNNING !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_count: time=%h run=%b, want 00005 1", sw2.TIME, sw2.RUNNING);
    end
    #2 rst2_n = 1'b0;
    #1;
    n_checks++;
    if (sw2.TIME !== 20'h0 || sw2.DISP !== 20'h0 || sw2.RUNNING !== 1'b0 ||
        sw2.DONE !== 1'b0 || sw2.LAP_HELD !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: time=%h disp=%h run=%b done=%b lap=%b, want all 0",
               sw2.TIME, sw2.DISP, sw2.RUNNING, sw2.DONE, sw2.LAP_HELD);
    end
    step();
    rst2_n = 1'b1;
  endtask

  initial begin
    sw1.TICK = 1'b0; sw1.START_STOP = 1'b0; sw1.CLEAR = 1'b0; sw1.LOAD = 1'b0;
    sw1.PRESET = '0; sw1.MODE = 1'b0; sw1.LAP = 1'b0;
    sw2.TICK = 1'b0; sw2.START_STOP = 1'b0; sw2.CLEAR = 1'b0; sw2.LOAD = 1'b0;
    sw2.PRESET = '0; sw2.MODE = 1'b0; sw2.LAP = 1'b0;
    test_reset();
    test_up_terminal();
    test_carry();
    test_load_saturate();
    test_down();
    test_lap();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Parametrised successor to the fixed mod-10/mod-6 stopwatch chain. Cascaded BCD time counter (tenths, seconds, tens-of-seconds, N minute digits) with run/pause control, up or down counting, preset load, a configurable terminal limit and a lap-hold display latch. Sits between the 10 Hz tick divider and the seven-segment display mux. Counts only on TICK enable pulses; everything runs on the single system clock.

Parameters:
MIN_DIGITS, 1, number of BCD minute digits (1..2)
MAX_MINUTES, 5, up-count terminal value in minutes (1..10^MIN_DIGITS-1); count stops at MAX_MINUTES:00.0
TW, 12+4*MIN_DIGITS, derived BCD time bus width, not overridable

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
TICK  in  1  one-CLK-wide 10 Hz count enable
START_STOP  in  1  one-cycle pulse: toggle run/pause
CLEAR  in  1  one-cycle pulse: synchronous clear to IDLE
LOAD  in  1  one-cycle pulse: load PRESET into time
PRESET  in  TW  BCD preset {minutes.., tens, secs, tenths}
MODE  in  1  0 = count up, 1 = count down; latched at start
LAP  in  1  one-cycle pulse: toggle display hold
TIME  out  TW  live BCD time
DISP  out  TW  display time (live, or held lap value)
RUNNING  out  1  state == RUN
DONE  out  1  state == DONE
LAP_HELD  out  1  display hold active

Behaviour:
- All outputs registered. Reset (RESET_N=0, async): TIME=0, DISP=0, state IDLE, latched mode=up, RUNNING=0, DONE=0, LAP_HELD=0.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority per edge: CLEAR > LOAD > START_STOP > LAP.
- CLEAR: any state -> IDLE, TIME=0, LAP_HELD=0.
- LOAD: accepted in IDLE/PAUSE/DONE, ignored in RUN. Copies PRESET, saturating each field independently (digits >9 -> 9, tens >5 -> 5). Next state IDLE.
- START_STOP:
  - In IDLE: latches MODE and goes to RUN.
  - Goes directly to DONE instead when start is already terminal: up with TIME >= MAX_MINUTES:00.0, or down with TIME = 0.
  - RUN -> PAUSE; PAUSE -> RUN; ignored in DONE.
- Counting: on an edge with TICK=1 and state RUN, TIME steps by ±0.1 s. Result is visible on TIME the cycle after that edge.
- Carry/borrow chain: tenths 9->0 (up) or 0->9 (down) carries into seconds; seconds 9<->0 into tens; tens 5<->0 into minutes; minute digits cascade as BCD.
- Terminal, up: the increment that yields MAX_MINUTES:00.0 writes that value and moves to DONE on the same edge. No further counting.
- Terminal, down: the decrement that yields 00:00.0 writes 0 and moves to DONE on the same edge.
- Simultaneous TICK + START_STOP: in RUN the tick is counted, then PAUSE. In PAUSE/IDLE the tick is not counted; counting starts at the next TICK.
- TICK outside RUN: no effect. MODE changes while not in IDLE: ignored.
- LAP in RUN: toggles LAP_HELD. On set, DISP freezes at the TIME value registered at that edge; on clear, DISP follows TIME again.
- LAP outside RUN clears LAP_HELD. Entering DONE clears LAP_HELD so DISP shows the final time.
- When LAP_HELD=0, DISP equals TIME (same cycle, both registered).
- Reset asserted mid-count: immediate return to reset values; no partial state kept.

Decomposition:
- stopwatch_pkg: state enum, digit width constant (4), digit limits (9, 5), TW function of MIN_DIGITS, PRESET saturation function.
- One sub-module, bcd_updown_digit, instantiated once per digit:
  - Parameter MOD (6 or 10).
  - Inputs: CE, UP, LOAD, D.
  - Outputs: Q, CARRY_OUT (at MOD-1 counting up, or 0 counting down).
  - CE chain formed in stopwatch_core.

Test Plan:
- Reset, START_STOP, 3000 TICKs, default params, up -> TIME 5:00.0 at tick 3000, DONE=1, RUNNING=0; 10 more TICKs leave TIME unchanged.
- Up count, 599 TICKs -> TIME 0:59.9; next TICK -> 1:00.0; single-edge carry across three digits.
- LOAD PRESET 0:01.2, MODE=1, START_STOP, 12 TICKs -> TIME 0:00.0, DONE=1; LOAD PRESET 0:00.0 then START_STOP -> DONE immediately, no TICK needed.
- RUN at 0:10.0; LAP -> DISP holds 0:10.0 while TIME reaches 0:15.0 after 50 TICKs; second LAP -> DISP=0:15.0.
- TICK and START_STOP on same edge in RUN at 0:02.0 -> TIME 0:02.1, state PAUSE. Repeat from PAUSE -> state RUN, TIME stays 0:02.1. CLEAR + LOAD same edge -> TIME 0, IDLE.
- MIN_DIGITS=2, MAX_MINUTES=12; LOAD PRESET 99:99.9 -> TIME 99:59.9 (saturated). Async RESET_N pulse mid-count -> all outputs 0 without a CLK edge.
